// File: rtl/game_speed_scheduler_pkg.sv
// Shared encodings and default timing constants for the game timebase.
package game_pkg;
  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_RUN   = 2'd1,
    GS_PAUSE = 2'd2,
    GS_OVER  = 2'd3
  } game_state_t;

  localparam int DEF_W           = 29;
  localparam int DEF_INIT_PERIOD = 572448;
  localparam int DEF_MIN_PERIOD  = 24080;
  localparam int DEF_STEP        = 128;
  localparam int DEF_LEAD        = 255;
endpackage

// File: rtl/game_speed_scheduler_tick_counter.sv
// Down-counter for the tick interval; load has priority over decrement.
module tick_counter #(
  parameter int           W         = 29,
  parameter int           LEAD      = 255,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         at_lead
);
  always_ff @(posedge clk) begin
    if (reset)       cnt <= RESET_VAL;
    else if (load)   cnt <= load_value;
    else if (enable) cnt <= cnt - W'(1);
  end

  assign zero    = (cnt == '0);
  assign at_lead = (cnt == W'(LEAD));
endmodule

// File: rtl/game_speed_scheduler.sv
// Run-control FSM and tick scheduler: owns period/level and emits tick, tick_early, tick_clock.
module game_speed_scheduler
  import game_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int INIT_PERIOD = DEF_INIT_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int STEP        = DEF_STEP,
  parameter int LEAD        = DEF_LEAD
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         start,
  input  logic         pause_toggle,
  input  logic         game_over,
  input  logic         key_press,
  output logic         tick,
  output logic         tick_early,
  output logic         tick_clock,
  output logic [W-1:0] period,
  output logic [7:0]   level,
  output logic [1:0]   state
);
  game_state_t  st;
  logic [W-1:0] cnt, cnt_load_val;
  logic         zero, at_lead;
  logic         run, active, do_over, do_pause, do_start, restart;
  logic         cnt_en, cnt_load, speed_ok, speed_up;

  assign state = st;

  // Only the highest-priority command that is legal in the current state takes effect.
  always_comb begin
    run          = (st == GS_RUN);
    active       = run || (st == GS_PAUSE);
    do_over      = game_over && active;
    do_pause     = !do_over && pause_toggle && active;
    do_start     = !do_over && !do_pause && start && (st == GS_IDLE || st == GS_OVER);
    restart      = do_start && (st == GS_OVER);
    cnt_en       = run && !do_over && !do_pause;
    cnt_load     = do_start || (cnt_en && zero);
    cnt_load_val = restart ? W'(INIT_PERIOD - 1) : period - W'(1);
    speed_ok     = {1'b0, period} >= (W+1)'(MIN_PERIOD + STEP);
    speed_up     = run && at_lead && speed_ok;
  end

  tick_counter #(
    .W         (W),
    .LEAD      (LEAD),
    .RESET_VAL (W'(INIT_PERIOD - 1))
  ) u_cnt (
    .clk        (CLOCK_50),
    .reset      (reset),
    .load       (cnt_load),
    .enable     (cnt_en),
    .load_value (cnt_load_val),
    .cnt        (cnt),
    .zero       (zero),
    .at_lead    (at_lead)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st         <= GS_IDLE;
      period     <= W'(INIT_PERIOD);
      level      <= 8'd0;
      tick       <= 1'b0;
      tick_early <= 1'b0;
      tick_clock <= 1'b0;
    end else begin
      // Pulses look at the state before any same-cycle transition.
      tick       <= run && zero;
      tick_early <= run && at_lead;
      tick_clock <= tick_clock ^ tick;

      if (do_over)       st <= GS_OVER;
      else if (do_pause) st <= run ? GS_PAUSE : GS_RUN;
      else if (do_start) st <= GS_RUN;

      if (key_press || restart) begin
        period <= W'(INIT_PERIOD);
        level  <= 8'd0;
      end else if (speed_up) begin
        period <= period - W'(STEP);
        if (level != 8'hff) level <= level + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_game_speed_scheduler.sv
// Bench for game_speed_scheduler: directed sequences, a command table and random stimulus vs a model.
module tb_game_speed_scheduler;
  localparam int W = 8, INIT = 40, MINP = 20, STEP = 8, LEAD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, pause_toggle = 1'b0, game_over = 1'b0, key_press = 1'b0;
  logic tick, tick_early, tick_clock;
  logic [W-1:0] period;
  logic [7:0] level;
  logic [1:0] state;

  game_speed_scheduler #(.W(W), .INIT_PERIOD(INIT), .MIN_PERIOD(MINP), .STEP(STEP), .LEAD(LEAD)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .pause_toggle(pause_toggle),
    .game_over(game_over), .key_press(key_press), .tick(tick), .tick_early(tick_early),
    .tick_clock(tick_clock), .period(period), .level(level), .state(state)
  );

  int tests = 0, fails = 0;

  // Model: interval of length m_len with m_e cycles already elapsed in it.
  int m_state = 0, m_len = INIT, m_e = 0, m_period = INIT, m_level = 0;
  int m_tick = 0, m_early = 0, m_tclk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    int run, len0, e0, per0, ns, en;
    if (reset) begin
      m_state = 0; m_len = INIT; m_e = 0; m_period = INIT; m_level = 0;
      m_tick = 0; m_early = 0; m_tclk = 0;
      return;
    end
    run = (m_state == 1); len0 = m_len; e0 = m_e; per0 = m_period;
    m_tclk  = m_tclk ^ m_tick;
    m_tick  = (run && e0 == len0 - 1) ? 1 : 0;
    m_early = (run && len0 - 1 - e0 == LEAD) ? 1 : 0;
    ns = m_state; en = run;
    if (game_over && (m_state == 1 || m_state == 2)) begin
      ns = 3; en = 0;
    end else if (pause_toggle && m_state == 1) begin
      ns = 2; en = 0;
    end else if (pause_toggle && m_state == 2) begin
      ns = 1;
    end else if (start && m_state == 0) begin
      ns = 1; m_len = per0; m_e = 0;
    end else if (start && m_state == 3) begin
      ns = 1; m_len = INIT; m_e = 0;
    end
    if (en) begin
      if (e0 == len0 - 1) begin m_len = per0; m_e = 0; end
      else m_e = e0 + 1;
    end
    if (key_press || (start && m_state == 3 && ns == 1)) begin
      m_period = INIT; m_level = 0;
    end else if (run && len0 - 1 - e0 == LEAD && per0 >= MINP + STEP) begin
      m_period = per0 - STEP;
      m_level  = (m_level < 255) ? m_level + 1 : 255;
    end
    m_state = ns;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    tests++;
    if (tick !== m_tick[0] || tick_early !== m_early[0] || tick_clock !== m_tclk[0] ||
        state !== m_state[1:0] || period !== m_period[W-1:0] || level !== m_level[7:0]) begin
      fails++;
      $display("FAIL model t=%0t: got tick=%b early=%b tclk=%b st=%0d per=%0d lvl=%0d expected %0d %0d %0d %0d %0d %0d",
               $time, tick, tick_early, tick_clock, state, period, level,
               m_tick, m_early, m_tclk, m_state, m_period, m_level);
    end
  endtask

  task automatic wait_tick(output int n, output int early_n);
    n = 0; early_n = -1;
    do begin
      step(); n++;
      if (tick_early && early_n < 0) early_n = n;
    end while (!tick && n < 200);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  typedef struct {
    logic rst, st, pt, go, key;
    int   exp_state;
  } vec_t;
  vec_t vt[15];

  initial begin
    int n, e, bad;
    int sp[4];
    vt[0]  = '{1,0,0,0,0,0};  vt[1]  = '{0,0,0,1,0,0};  vt[2]  = '{0,0,1,0,0,0};
    vt[3]  = '{0,1,0,1,0,1};  vt[4]  = '{0,1,0,0,0,1};  vt[5]  = '{0,0,1,0,0,2};
    vt[6]  = '{0,1,0,0,0,2};  vt[7]  = '{0,1,1,0,0,1};  vt[8]  = '{0,0,1,0,0,2};
    vt[9]  = '{0,0,1,1,0,3};  vt[10] = '{0,0,1,0,0,3};  vt[11] = '{0,1,1,0,1,1};
    vt[12] = '{0,1,1,1,0,3};  vt[13] = '{0,0,0,0,1,3};  vt[14] = '{1,1,0,0,0,0};

    // 1: reset, start, first tick timing and first speed-up
    reset = 1; step(); reset = 0;
    chk("rst_state", state, 0); chk("rst_period", period, INIT); chk("rst_level", level, 0);
    chk("rst_tick", tick, 0); chk("rst_tclk", tick_clock, 0);
    start = 1; step(); start = 0;
    wait_tick(n, e);
    chk("first_tick", n, 40); chk("first_early", e, 37);
    chk("t1_period", period, 32); chk("t1_level", level, 1);

    // 2: spacing shrinks to the floor
    sp = '{32, 24, 24, 24};
    foreach (sp[i]) begin wait_tick(n, e); chk("spacing", n, sp[i]); end
    chk("t2_level", level, 2); chk("t2_period", period, 24);

    // 3: pause at cnt=10 for 50 cycles
    repeat (13) step();
    pause_toggle = 1; step(); pause_toggle = 0;
    chk("paused", state, 2);
    bad = 0;
    repeat (50) begin step(); if (tick || tick_early) bad++; end
    chk("pause_pulses", bad, 0);
    pause_toggle = 1; step(); pause_toggle = 0;
    chk("resumed", state, 1);
    wait_tick(n, e); chk("resume_tick", n, 11);

    // 4: key_press on the lead cycle beats the speed-up
    key_press = 1; step(); key_press = 0;
    repeat (19) step();
    key_press = 1; step(); key_press = 0;
    chk("t4_early", tick_early, 1); chk("t4_period", period, 40); chk("t4_level", level, 0);
    wait_tick(n, e); chk("t4_rem", n, 3);
    wait_tick(n, e); chk("t4_len", n, 40);

    // 5: game over then restart
    game_over = 1; step(); game_over = 0;
    chk("t5_over", state, 3);
    bad = 0;
    repeat (20) begin step(); if (tick || tick_early) bad++; end
    chk("over_pulses", bad, 0);
    start = 1; step(); start = 0;
    chk("t5_state", state, 1); chk("t5_period", period, 40); chk("t5_level", level, 0);
    wait_tick(n, e); chk("t5_tick", n, 40);

    // 6: simultaneous commands, then mid-interval reset
    repeat (5) step();
    game_over = 1; pause_toggle = 1; start = 1; step();
    game_over = 0; pause_toggle = 0; start = 0;
    chk("t6_over", state, 3);
    start = 1; step(); start = 0;
    repeat (36) step();
    reset = 1; step(); reset = 0;
    chk("t6_state", state, 0); chk("t6_tick", tick, 0); chk("t6_early", tick_early, 0);
    chk("t6_tclk", tick_clock, 0); chk("t6_period", period, 40); chk("t6_level", level, 0);

    // command table
    foreach (vt[i]) begin
      reset = vt[i].rst; start = vt[i].st; pause_toggle = vt[i].pt;
      game_over = vt[i].go; key_press = vt[i].key;
      step();
      chk($sformatf("vec%0d_state", i), state, vt[i].exp_state);
    end
    reset = 0; start = 0; pause_toggle = 0; game_over = 0; key_press = 0;

    // random stimulus vs model
    repeat (5000) begin
      reset        = ($urandom_range(0, 599) == 0);
      start        = ($urandom_range(0, 29) == 0);
      pause_toggle = ($urandom_range(0, 39) == 0);
      game_over    = ($urandom_range(0, 149) == 0);
      key_press    = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
